// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage - data-memory req/ack transaction, load align/extend, store lanes, MEM/WB register.
// Optional feature macro: DMEM_TIMEOUT_EN aborts a WAIT that lasts TIMEOUT_CYCLES cycles without an ack.
module mem_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [31:0] alu_res_mem,
   input  logic [31:0] bypass_op2_mem,
   input  logic        mem_read_mem,
   input  logic        mem_write_mem,
   input  logic [1:0]  mask_mem,
   input  logic        unsigned_load_mem,
   input  logic        reg_write_mem,
   input  logic        mem_to_reg_mem,
   input  logic [4:0]  rd_addr_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stallreq_mem,
   output logic        reg_write_wb,
   output logic [4:0]  rd_addr_wb,
   output logic [31:0] wb_data_wb,
   output logic        misalign_wb,
   output logic        bus_timeout_wb
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
`ifdef DMEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   state_t        state, state_n;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   rdata_q, rdata_src, load_data, wb_data;
   logic [15:0]   ld_half;
   logic [7:0]    ld_byte;
   logic [3:0]    lane_be;
   logic          access, misaligned, timeout, to_q, to_flag, unused_stall;

   assign unused_stall = |stall[3:0];
   assign access       = mem_read_mem | mem_write_mem;
   assign misaligned   = access & (((mask_mem == 2'b01) & alu_res_mem[0]) |
                                   ((mask_mem == 2'b10) & (|alu_res_mem[1:0])) |
                                   (mask_mem == 2'b11));
   assign timeout      = TO_EN & (state == WAIT) & (wait_cnt == CW'(TIMEOUT_CYCLES)) & ~dmem_ack;
   assign to_flag      = timeout | ((state == DONE) & to_q);

   // Next state and bus request; DONE keeps the finished access from being re-issued while MEM is held
   always_comb begin
      state_n  = state;
      dmem_req = 1'b0;
      if (state == IDLE) begin
         dmem_req = access & ~misaligned;
         if (dmem_req) state_n = dmem_ack ? (stall[4] ? DONE : IDLE) : WAIT;
      end else if (state == WAIT) begin
         dmem_req = ~timeout;
         if (dmem_ack | timeout) state_n = stall[4] ? DONE : IDLE;
      end else if (!stall[4]) begin
         state_n = IDLE;
      end
   end

   assign stallreq_mem = dmem_req & ~dmem_ack;
   assign dmem_we      = dmem_req & mem_write_mem;
   assign dmem_addr    = {alu_res_mem[31:2], 2'b00};
   assign lane_be      = (mask_mem == 2'b00) ? 4'b0001 << alu_res_mem[1:0] :
                         (mask_mem == 2'b01) ? 4'b0011 << {alu_res_mem[1], 1'b0} : 4'hF;
   assign dmem_be      = dmem_req ? lane_be : 4'h0;
   assign dmem_wdata   = (mask_mem == 2'b00) ? {4{bypass_op2_mem[7:0]}} :
                         (mask_mem == 2'b01) ? {2{bypass_op2_mem[15:0]}} : bypass_op2_mem;

   assign rdata_src = (state == DONE) ? rdata_q : dmem_rdata;
   assign ld_byte   = rdata_src[{alu_res_mem[1:0], 3'b000} +: 8];
   assign ld_half   = rdata_src[{alu_res_mem[1], 4'b0000} +: 16];
   assign load_data = (mask_mem == 2'b00) ? {{24{~unsigned_load_mem & ld_byte[7]}}, ld_byte} :
                      (mask_mem == 2'b01) ? {{16{~unsigned_load_mem & ld_half[15]}}, ld_half} : rdata_src;
   assign wb_data   = mem_to_reg_mem ? load_data : alu_res_mem;

   // FSM state, WAIT-cycle counter, read data held for DONE and the timeout reason carried through DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rdata_q  <= '0;
         to_q     <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (dmem_req & dmem_ack) rdata_q <= dmem_rdata;
         to_q     <= (state == DONE) ? to_q : timeout;
      end
   end

   // MEM/WB register: bubble when MEM is held alone, freeze when WB is held too, otherwise capture
   always_ff @(posedge clk) begin
      if (rst | (stall[4] & ~stall[5])) begin
         reg_write_wb   <= 1'b0;
         rd_addr_wb     <= '0;
         wb_data_wb     <= '0;
         misalign_wb    <= 1'b0;
         bus_timeout_wb <= 1'b0;
      end else if (!stall[4]) begin
         reg_write_wb   <= reg_write_mem & ~misaligned & ~to_flag;
         rd_addr_wb     <= rd_addr_mem;
         wb_data_wb     <= wb_data;
         misalign_wb    <= misaligned;
         bus_timeout_wb <= to_flag;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven vectors plus directed multi-cycle sequences for mem_access.
module tb_mem_access;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        stall4_ext, stall5_ext;
   logic [31:0] alu_res_mem, bypass_op2_mem, dmem_addr, dmem_wdata, dmem_rdata, wb_data_wb;
   logic        mem_read_mem, mem_write_mem, unsigned_load_mem, reg_write_mem, mem_to_reg_mem;
   logic [1:0]  mask_mem;
   logic [4:0]  rd_addr_mem, rd_addr_wb;
   logic        dmem_req, dmem_we, dmem_ack, stallreq_mem, reg_write_wb, misalign_wb, bus_timeout_wb;
   logic [3:0]  dmem_be;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      string       name;
      bit          rd, wr;
      logic [1:0]  mask;
      bit          uns, rw, m2r;
      logic [4:0]  rda;
      logic [31:0] addr, op2, rdata;
      int          dly;
      bit          req, we;
      logic [3:0]  be;
      logic [31:0] wdata, daddr;
      int          stl;
      logic [31:0] wbd;
      bit          chk_d, wrw, wmis;
   } vec_t;

   vec_t vt[15];

   mem_access #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .alu_res_mem(alu_res_mem), .bypass_op2_mem(bypass_op2_mem),
      .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .mask_mem(mask_mem),
      .unsigned_load_mem(unsigned_load_mem), .reg_write_mem(reg_write_mem),
      .mem_to_reg_mem(mem_to_reg_mem), .rd_addr_mem(rd_addr_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stallreq_mem(stallreq_mem), .reg_write_wb(reg_write_wb), .rd_addr_wb(rd_addr_wb),
      .wb_data_wb(wb_data_wb), .misalign_wb(misalign_wb), .bus_timeout_wb(bus_timeout_wb)
   );

   always #5 clk = ~clk;

   // The pipeline controller holds MEM (and earlier stages) whenever MEM asks for a stall
   assign stall = {stall5_ext, stall4_ext | stallreq_mem, {4{stall4_ext | stallreq_mem}}};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", what, act, exp);
      end
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [1:0] mask, input bit uns, input bit rw,
                        input bit m2r, input logic [4:0] rda, input logic [31:0] addr, input logic [31:0] op2);
      mem_read_mem      = rd;
      mem_write_mem     = wr;
      mask_mem          = mask;
      unsigned_load_mem = uns;
      reg_write_mem     = rw;
      mem_to_reg_mem    = m2r;
      rd_addr_mem       = rda;
      alu_res_mem       = addr;
      bypass_op2_mem    = op2;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      dmem_ack = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int cyc, stl;
      bit done;
      @(posedge clk); #1;
      drive(v.rd, v.wr, v.mask, v.uns, v.rw, v.m2r, v.rda, v.addr, v.op2);
      dmem_rdata = v.rdata;
      dmem_ack   = (v.dly == 0) && v.req;
      #3;
      chk({v.name, " req"},   32'(dmem_req),   32'(v.req));
      chk({v.name, " we"},    32'(dmem_we),    32'(v.we));
      chk({v.name, " be"},    32'(dmem_be),    32'(v.be));
      chk({v.name, " wdata"}, dmem_wdata,      v.wdata);
      chk({v.name, " addr"},  dmem_addr,       v.daddr);
      stl  = 0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
            dmem_ack = (cyc == v.dly) && v.req;
            #3;
         end
         if (stallreq_mem) stl++;
         done = !dmem_req || dmem_ack;
         cyc++;
      end
      chk({v.name, " completed"}, 32'(done), 32'd1);
      @(posedge clk); #1;
      nop();
      chk({v.name, " stall_cycles"}, stl, v.stl);
      chk({v.name, " reg_write_wb"}, 32'(reg_write_wb), 32'(v.wrw));
      chk({v.name, " rd_addr_wb"},   32'(rd_addr_wb),   32'(v.rda));
      chk({v.name, " misalign_wb"},  32'(misalign_wb),  32'(v.wmis));
      chk({v.name, " timeout_wb"},   32'(bus_timeout_wb), 32'd0);
      if (v.chk_d) chk({v.name, " wb_data"}, wb_data_wb, v.wbd);
   endtask

   initial begin
      int stl, xact;
      // name rd wr mask uns rw m2r rda addr op2 rdata dly | req we be wdata daddr stl wbd chk_d wrw wmis
      vt[0]  = '{"lw",      1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd5,  32'h100, 32'h0, 32'hDEADBEEF, 0,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h100, 0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
      vt[1]  = '{"lb",      1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5'd6,  32'h103, 32'h0, 32'h80112233, 3,
                 1'b1, 1'b0, 4'b1000, 32'h0, 32'h100, 3, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{"lbu",     1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 5'd6,  32'h103, 32'h0, 32'h80112233, 3,
                 1'b1, 1'b0, 4'b1000, 32'h0, 32'h100, 3, 32'h00000080, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{"sh",      1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0A, 32'h1234ABCD, 32'h0, 1,
                 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h08, 1, 32'h0A, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{"lw_mis",  1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd5,  32'h102, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h100, 0, 32'h0, 1'b0, 1'b0, 1'b1};
      vt[5]  = '{"lh",      1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 5'd7,  32'h202, 32'h0, 32'h80017FFF, 2,
                 1'b1, 1'b0, 4'b1100, 32'h0, 32'h200, 2, 32'hFFFF8001, 1'b1, 1'b1, 1'b0};
      vt[6]  = '{"lhu",     1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd8,  32'h200, 32'h0, 32'h12348765, 0,
                 1'b1, 1'b0, 4'b0011, 32'h0, 32'h200, 0, 32'h00008765, 1'b1, 1'b1, 1'b0};
      vt[7]  = '{"sb",      1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0,  32'h101, 32'hA5, 32'h0, 0,
                 1'b1, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h100, 0, 32'h101, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{"sw",      1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0,  32'h304, 32'hCAFEF00D, 32'h0, 0,
                 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h304, 0, 32'h304, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{"ld_st",   1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0,  32'h40, 32'h11223344, 32'h0, 0,
                 1'b1, 1'b1, 4'hF, 32'h11223344, 32'h40, 0, 32'h40, 1'b1, 1'b0, 1'b0};
      vt[10] = '{"rsvd",    1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 5'd2,  32'h0, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b1};
      vt[11] = '{"alu",     1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 5'd3,  32'h12345678, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h12345678, 0, 32'h12345678, 1'b1, 1'b1, 1'b0};
      vt[12] = '{"lh_mis",  1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 5'd4,  32'h201, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h200, 0, 32'h0, 1'b0, 1'b0, 1'b1};
      vt[13] = '{"lb0",     1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9,  32'h104, 32'h0, 32'h0000007F, 0,
                 1'b1, 1'b0, 4'b0001, 32'h0, 32'h104, 0, 32'h0000007F, 1'b1, 1'b1, 1'b0};
      vt[14] = '{"alu_odd", 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 5'd10, 32'h33, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h30, 0, 32'h33, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      stall4_ext = 1'b0;
      stall5_ext = 1'b0;
      dmem_rdata = 32'h0;
      nop();
      repeat (2) @(posedge clk);
      #1;
      chk("reset req",       32'(dmem_req),     32'd0);
      chk("reset we",        32'(dmem_we),      32'd0);
      chk("reset be",        32'(dmem_be),      32'd0);
      chk("reset stallreq",  32'(stallreq_mem), 32'd0);
      chk("reset reg_write", 32'(reg_write_wb), 32'd0);
      chk("reset wb_data",   wb_data_wb,        32'd0);
      chk("reset misalign",  32'(misalign_wb),  32'd0);
      chk("reset timeout",   32'(bus_timeout_wb), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(vt[i]);

      // Ack arrives while MEM and WB are both held: one transaction, data delivered after release
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 5'd3, 32'h12345678, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd12, 32'h100, 32'h0);
      stall4_ext = 1'b1;
      stall5_ext = 1'b1;
      dmem_rdata = 32'hA5A50001;
      dmem_ack   = 1'b1;
      #3;
      chk("hold first req", 32'(dmem_req), 32'd1);
      xact = (dmem_req && dmem_ack) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         dmem_ack   = 1'b0;
         dmem_rdata = 32'hBAD0BAD0;
         #3;
         chk("hold done req", 32'(dmem_req), 32'd0);
         if (dmem_req && dmem_ack) xact++;
         chk("hold wb rd", 32'(rd_addr_wb), 32'd3);
         chk("hold wb data", wb_data_wb, 32'h12345678);
      end
      chk("hold transactions", xact, 1);
      @(posedge clk); #1;
      stall4_ext = 1'b0;
      stall5_ext = 1'b0;
      #3;
      chk("release req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      nop();
      chk("release wb data", wb_data_wb, 32'hA5A50001);
      chk("release wb rd",   32'(rd_addr_wb),   32'd12);
      chk("release wb rw",   32'(reg_write_wb), 32'd1);

      // MEM held alone inserts a bubble into WB
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 5'd13, 32'h77, 32'h0);
      stall4_ext = 1'b1;
      @(posedge clk); #1;
      chk("bubble rw",   32'(reg_write_wb), 32'd0);
      chk("bubble rd",   32'(rd_addr_wb),   32'd0);
      chk("bubble data", wb_data_wb,        32'd0);
      stall4_ext = 1'b0;
      @(posedge clk); #1;
      nop();
      chk("after bubble rw",   32'(reg_write_wb), 32'd1);
      chk("after bubble data", wb_data_wb,        32'h77);

      // Long wait without ack
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd14, 32'h100, 32'h0);
      dmem_rdata = 32'h0BADF00D;
      stl = 0;
`ifdef DMEM_TIMEOUT_EN
      for (int i = 0; i < 9; i++) begin
         #3;
         if (stallreq_mem) stl++;
         @(posedge clk); #1;
      end
      #3;
      chk("timeout stallreq", 32'(stallreq_mem), 32'd0);
      chk("timeout stall_cycles", stl, 9);
      @(posedge clk); #1;
      nop();
      chk("timeout flag", 32'(bus_timeout_wb), 32'd1);
      chk("timeout rw",   32'(reg_write_wb),   32'd0);
`else
      for (int i = 0; i < 12; i++) begin
         #3;
         if (stallreq_mem) stl++;
         @(posedge clk); #1;
      end
      dmem_ack = 1'b1;
      #3;
      chk("long wait req", 32'(dmem_req), 32'd1);
      chk("long wait ack stallreq", 32'(stallreq_mem), 32'd0);
      chk("long wait stall_cycles", stl, 12);
      @(posedge clk); #1;
      nop();
      chk("long wait timeout flag", 32'(bus_timeout_wb), 32'd0);
      chk("long wait rw",   32'(reg_write_wb), 32'd1);
      chk("long wait data", wb_data_wb,        32'h0BADF00D);
`endif

      // Reset in the middle of WAIT; a late ack is ignored
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd15, 32'h200, 32'h0);
      #3;
      chk("rstwait stallreq", 32'(stallreq_mem), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      nop();
      #3;
      chk("rstwait req in wait", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h0000FFFF;
      #3;
      chk("rstwait req dropped",  32'(dmem_req),     32'd0);
      chk("rstwait stallreq off", 32'(stallreq_mem), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("rstwait late ack rw", 32'(reg_write_wb), 32'd0);
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd16, 32'h104, 32'h0);
      dmem_rdata = 32'h13579BDF;
      dmem_ack   = 1'b1;
      #3;
      chk("post reset req", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      nop();
      chk("post reset data", wb_data_wb,        32'h13579BDF);
      chk("post reset rd",   32'(rd_addr_wb),   32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
